// File: rtl/axil2lb_pkg.sv
// Shared response codes and FSM state types for the AXI4-Lite to local-bus bridge.
package axil2lb_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_BUS  = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_BUS  = 2'd1,
    R_RESP = 2'd2
  } rd_state_e;

endpackage

// File: rtl/axil2lb_bridge.sv
// AXI4-Lite slave to local-bus master bridge; independent read and write FSMs,
// one outstanding transaction per direction.
// Optional local-bus wait timeout: define AXIL2LB_TIMEOUT_EN.
module axil2lb_bridge
  import axil2lb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned STRB_W      = DATA_W / 8,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [DATA_W-1:0] s_axi_wdata,
  input  logic [STRB_W-1:0] s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [ADDR_W-1:0] lb_waddr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic [STRB_W-1:0] lb_wstrb,
  output logic              lb_wen,
  input  logic              lb_wready,
  output logic [ADDR_W-1:0] lb_raddr,
  output logic              lb_ren,
  input  logic [DATA_W-1:0] lb_rdata,
  input  logic              lb_rvalid
);

  wr_state_e         wr_state, wr_state_n;
  rd_state_e         rd_state, rd_state_n;
  logic              aw_held, aw_held_n, w_held, w_held_n;
  logic [ADDR_W-1:0] waddr_n, raddr_n;
  logic [DATA_W-1:0] wdata_n, rdata_n;
  logic [STRB_W-1:0] wstrb_n;
  logic              wen_n, ren_n;
  logic              awready_n, wready_n, arready_n;
  logic              bvalid_n, rvalid_n;
  logic [1:0]        bresp_n, rresp_n;
  logic              wr_tmo_c, rd_tmo_c;

`ifdef AXIL2LB_TIMEOUT_EN
  localparam int unsigned TMO_RAW_W = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned TMO_W     = (TMO_RAW_W < 8) ? 8 : ((TMO_RAW_W > 16) ? 16 : TMO_RAW_W);
  logic [TMO_W-1:0] wr_cnt, rd_cnt;

  // Count cycles spent waiting on the local bus; cleared outside the bus states
  always_ff @(posedge clk) begin
    if (rst || wr_state != W_BUS) wr_cnt <= '0;
    else                          wr_cnt <= wr_cnt + TMO_W'(1);
    if (rst || rd_state != R_BUS) rd_cnt <= '0;
    else                          rd_cnt <= rd_cnt + TMO_W'(1);
  end

  assign wr_tmo_c = (wr_state == W_BUS) && (wr_cnt == TMO_W'(TIMEOUT_CYC - 1));
  assign rd_tmo_c = (rd_state == R_BUS) && (rd_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
  assign wr_tmo_c = 1'b0;
  assign rd_tmo_c = 1'b0;
`endif

  // Write path next state: collect AW and W in any order, issue one local write, respond
  always_comb begin
    wr_state_n = wr_state;
    aw_held_n  = aw_held;
    w_held_n   = w_held;
    waddr_n    = lb_waddr;
    wdata_n    = lb_wdata;
    wstrb_n    = lb_wstrb;
    wen_n      = lb_wen;
    awready_n  = s_axi_awready;
    wready_n   = s_axi_wready;
    bvalid_n   = s_axi_bvalid;
    bresp_n    = s_axi_bresp;
    case (wr_state)
      W_IDLE: begin
        if (s_axi_awvalid && s_axi_awready) begin
          aw_held_n = 1'b1;
          waddr_n   = s_axi_awaddr;
        end
        if (s_axi_wvalid && s_axi_wready) begin
          w_held_n = 1'b1;
          wdata_n  = s_axi_wdata;
          wstrb_n  = s_axi_wstrb;
        end
        if (aw_held_n && w_held_n) begin
          wr_state_n = W_BUS;
          wen_n      = 1'b1;
          aw_held_n  = 1'b0;
          w_held_n   = 1'b0;
        end
        awready_n = (wr_state_n == W_IDLE) && !aw_held_n;
        wready_n  = (wr_state_n == W_IDLE) && !w_held_n;
      end
      W_BUS: begin
        if ((lb_wen && lb_wready) || wr_tmo_c) begin
          wr_state_n = W_RESP;
          wen_n      = 1'b0;
          bvalid_n   = 1'b1;
          bresp_n    = (lb_wen && lb_wready) ? RESP_OKAY : RESP_SLVERR;
        end
      end
      W_RESP: begin
        if (s_axi_bvalid && s_axi_bready) begin
          wr_state_n = W_IDLE;
          bvalid_n   = 1'b0;
          bresp_n    = RESP_OKAY;
          awready_n  = 1'b1;
          wready_n   = 1'b1;
        end
      end
      default: wr_state_n = W_IDLE;
    endcase
  end

  // Read path next state: accept AR, hold lb_ren until data returns, respond
  always_comb begin
    rd_state_n = rd_state;
    raddr_n    = lb_raddr;
    ren_n      = lb_ren;
    arready_n  = s_axi_arready;
    rvalid_n   = s_axi_rvalid;
    rresp_n    = s_axi_rresp;
    rdata_n    = s_axi_rdata;
    case (rd_state)
      R_IDLE: begin
        arready_n = 1'b1;
        if (s_axi_arvalid && s_axi_arready) begin
          rd_state_n = R_BUS;
          raddr_n    = s_axi_araddr;
          ren_n      = 1'b1;
          arready_n  = 1'b0;
        end
      end
      R_BUS: begin
        if (lb_ren && lb_rvalid) begin
          rd_state_n = R_RESP;
          rdata_n    = lb_rdata;
          ren_n      = 1'b0;
          rvalid_n   = 1'b1;
          rresp_n    = RESP_OKAY;
        end else if (rd_tmo_c) begin
          rd_state_n = R_RESP;
          rdata_n    = '0;
          ren_n      = 1'b0;
          rvalid_n   = 1'b1;
          rresp_n    = RESP_SLVERR;
        end
      end
      R_RESP: begin
        if (s_axi_rvalid && s_axi_rready) begin
          rd_state_n = R_IDLE;
          rvalid_n   = 1'b0;
          rresp_n    = RESP_OKAY;
          rdata_n    = '0;
          arready_n  = 1'b1;
        end
      end
      default: rd_state_n = R_IDLE;
    endcase
  end

  // Register all state and outputs; reset abandons anything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state      <= W_IDLE;
      rd_state      <= R_IDLE;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      lb_waddr      <= '0;
      lb_wdata      <= '0;
      lb_wstrb      <= '0;
      lb_wen        <= 1'b0;
      lb_raddr      <= '0;
      lb_ren        <= 1'b0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      s_axi_rvalid  <= 1'b0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rdata   <= '0;
    end else begin
      wr_state      <= wr_state_n;
      rd_state      <= rd_state_n;
      aw_held       <= aw_held_n;
      w_held        <= w_held_n;
      lb_waddr      <= waddr_n;
      lb_wdata      <= wdata_n;
      lb_wstrb      <= wstrb_n;
      lb_wen        <= wen_n;
      lb_raddr      <= raddr_n;
      lb_ren        <= ren_n;
      s_axi_awready <= awready_n;
      s_axi_wready  <= wready_n;
      s_axi_arready <= arready_n;
      s_axi_bvalid  <= bvalid_n;
      s_axi_bresp   <= bresp_n;
      s_axi_rvalid  <= rvalid_n;
      s_axi_rresp   <= rresp_n;
      s_axi_rdata   <= rdata_n;
    end
  end

endmodule

// File: tb/tb_axil2lb_bridge.sv
// Self-checking bench for axil2lb_bridge: directed latency/boundary cases plus
// randomized writes/reads against a register-array reference model.
`timescale 1ns/1ps
module tb_axil2lb_bridge;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rvalid, s_axi_rready;
  logic [31:0] lb_waddr, lb_wdata, lb_raddr, lb_rdata;
  logic [3:0]  lb_wstrb;
  logic        lb_wen, lb_wready, lb_ren, lb_rvalid;

  always #5 clk = ~clk;

  axil2lb_bridge #(.ADDR_W(32), .DATA_W(32), .STRB_W(4), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .lb_waddr(lb_waddr), .lb_wdata(lb_wdata), .lb_wstrb(lb_wstrb), .lb_wen(lb_wen),
    .lb_wready(lb_wready), .lb_raddr(lb_raddr), .lb_ren(lb_ren), .lb_rdata(lb_rdata),
    .lb_rvalid(lb_rvalid)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] slave_regs [16];
  logic [31:0] model [16];
  int wen_hs = 0, wen_cycles = 0, ren_hs = 0, b_hs = 0, r_hs = 0;
  bit wr_rand = 1'b0, wr_stall = 1'b0, rd_stall = 1'b0, rd_late = 1'b0;
  int rd_lat = 1;
  int ren_age = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // Peripheral register file and handshake counters, updated on the clock edge
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) slave_regs[i] <= '0;
    end else begin
      if (lb_wen) wen_cycles <= wen_cycles + 1;
      if (lb_wen && lb_wready) begin
        wen_hs <= wen_hs + 1;
        slave_regs[lb_waddr[5:2]] <= merge(slave_regs[lb_waddr[5:2]], lb_wdata, lb_wstrb);
      end
      if (lb_ren && lb_rvalid) ren_hs <= ren_hs + 1;
      if (s_axi_bvalid && s_axi_bready) b_hs <= b_hs + 1;
      if (s_axi_rvalid && s_axi_rready) r_hs <= r_hs + 1;
    end
  end

  // Local-bus slave: wready per mode, rvalid after rd_lat cycles of lb_ren
  initial begin
    lb_wready = 1'b0; lb_rvalid = 1'b0; lb_rdata = '0;
    forever begin
      @(negedge clk);
      lb_wready = wr_stall ? 1'b0 : (wr_rand ? 1'($urandom_range(0, 1)) : 1'b1);
      if (lb_ren) ren_age++; else ren_age = 0;
      if (rd_late) begin
        lb_rvalid = 1'b1; lb_rdata = 32'hDEAD_BEEF;
      end else if (lb_ren && !rd_stall && ren_age > rd_lat) begin
        lb_rvalid = 1'b1; lb_rdata = slave_regs[lb_raddr[5:2]];
      end else begin
        lb_rvalid = 1'b0; lb_rdata = $urandom;
      end
    end
  end

  task automatic aw_w_send(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly);
    bit aw_done = 1'b0, w_done = 1'b0;
    int cyc = 0;
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    while (!(aw_done && w_done) && cyc < 100) begin
      s_axi_awvalid = !aw_done && cyc >= aw_dly;
      s_axi_wvalid  = !w_done && cyc >= w_dly;
      if (s_axi_awvalid && s_axi_awready) aw_done = 1'b1;
      if (s_axi_wvalid && s_axi_wready) w_done = 1'b1;
      @(negedge clk); cyc++;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    chk("aw_w_handshake", {aw_done, w_done}, 2'b11);
  endtask

  task automatic wait_b(input int dly, output logic [1:0] resp);
    int n = 0;
    bit got = 1'b0;
    while (n < 200) begin
      s_axi_bready = (n >= dly);
      if (s_axi_bvalid && s_axi_bready) begin got = 1'b1; break; end
      @(negedge clk); n++;
    end
    chk("bvalid_seen", got, 1'b1);
    resp = s_axi_bresp;
    @(negedge clk);
    s_axi_bready = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] a);
    int n = 0;
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    while (!s_axi_arready && n < 100) begin @(negedge clk); n++; end
    chk("ar_handshake", s_axi_arready, 1'b1);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
  endtask

  task automatic wait_r(input int dly, output logic [31:0] data, output logic [1:0] resp);
    int n = 0, h = 0;
    bit seen = 1'b0;
    logic [31:0] first = '0;
    while (n < 300) begin
      if (s_axi_rvalid) begin
        if (!seen) begin seen = 1'b1; first = s_axi_rdata; end
        else begin
          chk("rdata_stable", s_axi_rdata, first);
          chk("arready_busy", s_axi_arready, 1'b0);
        end
        s_axi_rready = (h >= dly); h++;
        if (s_axi_rready) break;
      end
      @(negedge clk); n++;
    end
    chk("rvalid_seen", seen, 1'b1);
    data = s_axi_rdata; resp = s_axi_rresp;
    @(negedge clk);
    s_axi_rready = 1'b0;
    chk("rdata_cleared", s_axi_rdata, 32'h0);
  endtask

  // Watchdog against a hung handshake
  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd, old_v, new_v;
    int base, base_b, base_r, n, idx;
    rst = 1'b1;
    s_axi_awaddr = '0; s_axi_awvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 0;
    s_axi_bready = 0; s_axi_araddr = '0; s_axi_arvalid = 0; s_axi_rready = 0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_awready", s_axi_awready, 0);
    chk("rst_wready", s_axi_wready, 0);
    chk("rst_arready", s_axi_arready, 0);
    chk("rst_valids", {s_axi_bvalid, s_axi_rvalid, lb_wen, lb_ren}, 4'b0000);
    chk("rst_regs", {lb_waddr, s_axi_rdata}, 64'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

    // Same-cycle AW+W with latency checks
    base = wen_hs;
    aw_w_send(32'h20, 32'h0000_A5A5, 4'b0011, 0, 0);
    model[8] = merge(model[8], 32'h0000_A5A5, 4'b0011);
    chk("t1_wen", lb_wen, 1);
    chk("t1_waddr", lb_waddr, 32'h20);
    chk("t1_wdata", lb_wdata, 32'h0000_A5A5);
    chk("t1_wstrb", lb_wstrb, 4'b0011);
    chk("t1_awready_low", {s_axi_awready, s_axi_wready}, 2'b00);
    @(negedge clk);
    chk("t1_wen_drop", lb_wen, 0);
    chk("t1_bvalid_lat", s_axi_bvalid, 1);
    wait_b(0, resp);
    chk("t1_bresp", resp, 2'b00);
    chk("t1_one_write", wen_hs - base, 1);
    chk("t1_gpio_out", slave_regs[8], model[8]);

    // W channel three cycles ahead of AW
    base = wen_cycles;
    aw_w_send(32'h20, 32'h1, 4'b0001, 3, 0);
    chk("t2_no_early_wen", wen_cycles - base, 0);
    model[8] = merge(model[8], 32'h1, 4'b0001);
    wait_b(2, resp);
    chk("t2_bresp", resp, 2'b00);
    chk("t2_one_wen", wen_cycles - base, 1);

    // Read with 1-cycle slave, latency, and rready held low 5 cycles
    aw_w_send(32'h20, 32'h0000_00F0, 4'b1111, 0, 0);
    model[8] = 32'h0000_00F0;
    wait_b(0, resp);
    rd_lat = 1;
    ar_send(32'h20);
    chk("t3_ren", lb_ren, 1);
    chk("t3_raddr", lb_raddr, 32'h20);
    @(negedge clk);
    chk("t3_ren_held", {lb_ren, s_axi_rvalid}, 2'b10);
    @(negedge clk);
    chk("t3_rvalid_lat", {lb_ren, s_axi_rvalid}, 2'b01);
    wait_r(5, rd, resp);
    chk("t3_rdata", rd, 32'h0000_00F0);
    chk("t3_rresp", resp, 2'b00);
    chk("t4_arready_next", s_axi_arready, 1);
    ar_send(32'h20);
    wait_r(0, rd, resp);
    chk("t4_rdata2", rd, model[8]);

    // Concurrent read and write to the same address
    base = wen_hs; base_b = b_hs; base_r = r_hs;
    old_v = model[8];
    new_v = merge(old_v, 32'h1234_5678, 4'b1111);
    fork
      begin
        aw_w_send(32'h20, 32'h1234_5678, 4'b1111, 0, 0);
        wait_b(1, resp);
        chk("t5_bresp", resp, 2'b00);
      end
      begin
        logic [31:0] d5;
        logic [1:0]  r5;
        ar_send(32'h20);
        wait_r(1, d5, r5);
        chk("t5_rdata_old_or_new", (d5 == old_v) || (d5 == new_v), 1'b1);
        chk("t5_rresp", r5, 2'b00);
      end
    join
    model[8] = new_v;
    repeat (2) @(negedge clk);
    chk("t5_one_b", b_hs - base_b, 1);
    chk("t5_one_r", r_hs - base_r, 1);
    chk("t5_one_write", wen_hs - base, 1);

    // Read stall: timeout in the timeout build, indefinite wait otherwise
    rd_stall = 1'b1;
    ar_send(32'h20);
    n = 0;
    while (lb_ren && n < 40) begin @(negedge clk); n++; end
`ifdef AXIL2LB_TIMEOUT_EN
    chk("tmo_ren_cycles", n, TMO);
    chk("tmo_rvalid", s_axi_rvalid, 1);
    chk("tmo_rresp", s_axi_rresp, 2'b10);
    chk("tmo_rdata", s_axi_rdata, 32'h0);
    rd_late = 1'b1;
    @(negedge clk);
    rd_late = 1'b0;
    @(negedge clk);
    chk("tmo_late_ignored", s_axi_rdata, 32'h0);
    wait_r(0, rd, resp);
    chk("tmo_resp_final", resp, 2'b10);
    rd_stall = 1'b0;
    // Write stall times out with SLVERR and no local write
    base = wen_hs;
    wr_stall = 1'b1;
    aw_w_send(32'h28, 32'hFFFF_FFFF, 4'b1111, 0, 0);
    n = 0;
    while (lb_wen && n < 40) begin @(negedge clk); n++; end
    chk("tmo_wen_cycles", n, TMO);
    wait_b(0, resp);
    chk("tmo_bresp", resp, 2'b10);
    chk("tmo_no_write", wen_hs - base, 0);
    wr_stall = 1'b0;
`else
    chk("notmo_ren_held", {lb_ren, s_axi_rvalid}, 2'b10);
    rd_stall = 1'b0;
    wait_r(0, rd, resp);
    chk("notmo_rdata", rd, model[8]);
    chk("notmo_rresp", resp, 2'b00);
    wr_stall = 1'b1;
    aw_w_send(32'h28, 32'hFFFF_FFFF, 4'b1111, 0, 0);
    repeat (20) @(negedge clk);
    chk("notmo_wen_held", {lb_wen, s_axi_bvalid}, 2'b10);
    wr_stall = 1'b0;
    wait_b(0, resp);
    chk("notmo_bresp", resp, 2'b00);
    model[10] = 32'hFFFF_FFFF;
`endif

    // Reset during an in-flight read: abandoned, no response
    base_r = r_hs;
    rd_stall = 1'b1;
    ar_send(32'h24);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_outputs", {s_axi_awready, s_axi_wready, s_axi_arready, lb_ren, s_axi_rvalid}, 5'b0);
    rst = 1'b0;
    rd_stall = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    repeat (4) @(negedge clk);
    chk("midrst_no_resp", {s_axi_rvalid, lb_ren}, 2'b00);
    chk("midrst_arready", s_axi_arready, 1);
    chk("midrst_r_count", r_hs - base_r, 0);

    // Randomized writes and reads against the reference model
    wr_rand = 1'b1;
    for (int it = 0; it < 40; it++) begin
      idx = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 0) begin
        logic [31:0] d;
        logic [3:0]  s;
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        base = wen_hs;
        aw_w_send(32'(idx) << 2, d, s, $urandom_range(0, 3), $urandom_range(0, 3));
        wait_b($urandom_range(0, 3), resp);
        model[idx] = merge(model[idx], d, s);
        chk("rnd_bresp", resp, 2'b00);
        chk("rnd_one_write", wen_hs - base, 1);
      end else begin
        rd_lat = $urandom_range(0, 3);
        ar_send(32'(idx) << 2);
        wait_r($urandom_range(0, 3), rd, resp);
        chk("rnd_rdata", rd, model[idx]);
        chk("rnd_rresp", resp, 2'b00);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
